// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit scheduler.
//   state_t          : playback FSM states (IDLE, PRIME, RUN)
//   SAMPLE_W         : stereo sample word width ([31:16] left, [15:0] right)
//   X64_PER_FRAME    : x64 enables per I2S frame
//   X512_PER_X64     : x512 enables per x64 enable
//   sat_inc16        : 16-bit saturating increment
package i2s_pkg;

  localparam int SAMPLE_W      = 32;
  localparam int X64_PER_FRAME = 64;
  localparam int X512_PER_X64  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO.
//   clk, rst      : clock, async active-high reset (empties the FIFO)
//   i_wr_en       : write request (ignored while full)
//   i_wr_data     : word to write
//   i_rd_en       : pop request (ignored while empty)
//   o_rd_data     : head word, valid whenever o_empty is low
//   o_level       : occupancy, 0..DEPTH
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [W-1:0]               i_wr_data,
  input  logic                       i_rd_en,
  output logic [W-1:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_wr;
  logic          w_rd;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Full refuses writes even when a pop happens in the same cycle.
  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  // Storage carries no reset; contents are only visible through a valid pointer.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S transmit scheduler: feeds an i2s_encoder with sample-rate enables,
// a run enable and one 32-bit stereo word per frame.
//   clk, rst            : clock, async active-high reset
//   start / stop        : one-cycle playback requests
//   s_data/s_valid/s_ready : producer write port into the sample FIFO
//   ena_sampleRatex512  : x512 enable, every CLK_DIV_X512 clocks
//   ena_sampleRatex64   : x64 enable, every 8th x512 enable (coincident)
//   ena, data           : encoder run enable and current frame word
//   running             : FSM is in RUN
//   underrun(_clr/_cnt) : sticky flag, its clear, saturating event count
//   fifo_level          : FIFO occupancy
module i2s_tx_scheduler
  import i2s_pkg::*;
#(
  parameter int CLK_DIV_X512 = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int START_LEVEL  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [SAMPLE_W-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          ena_sampleRatex512,
  output logic                          ena_sampleRatex64,
  output logic                          ena,
  output logic [SAMPLE_W-1:0]           data,
  output logic                          running,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [15:0]                   underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(CLK_DIV_X512);
  localparam int SW = $clog2(X512_PER_X64);
  localparam int PW = $clog2(X64_PER_FRAME);

  // ---------------- enable generator (free running) ----------------
  logic [DW-1:0] r_div_cnt;
  logic [SW-1:0] r_sub;
  logic [PW-1:0] r_phase;
  logic          w_x512;
  logic          w_x64;
  logic          w_boundary;

  assign w_x512 = (r_div_cnt == DW'(CLK_DIV_X512 - 1));
  assign w_x64  = w_x512 && (r_sub == SW'(X512_PER_X64 - 1));
  assign w_boundary = w_x64 && (r_phase == PW'(X64_PER_FRAME - 1));

  assign ena_sampleRatex512 = w_x512;
  assign ena_sampleRatex64  = w_x64;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_sub     <= '0;
    end else begin
      r_div_cnt <= w_x512 ? '0 : r_div_cnt + DW'(1);
      if (w_x512) r_sub <= (r_sub == SW'(X512_PER_X64 - 1)) ? '0 : r_sub + SW'(1);
    end
  end

  // ---------------- sample FIFO ----------------
  logic [SAMPLE_W-1:0] w_rd_data;
  logic [LW-1:0]       w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  assign s_ready    = !w_full;
  assign fifo_level = w_level;
  assign w_push     = s_valid && s_ready;

  i2s_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (s_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // ---------------- playback FSM ----------------
  state_t              r_state;
  logic                r_stop_pending;
  logic                r_ena;
  logic                r_running;
  logic [SAMPLE_W-1:0] r_data;
  logic                r_underrun;
  logic [15:0]         r_underrun_cnt;
  logic                w_enter_run;
  logic                w_stop_now;
  logic                w_underrun_set;

  // A stop landing on the boundary cycle itself still ends this frame.
  assign w_stop_now  = r_stop_pending || stop;
  assign w_enter_run = (r_state == PRIME) && !stop && w_x64 &&
                       (w_level >= LW'(START_LEVEL));
  assign w_pop = w_enter_run ||
                 ((r_state == RUN) && w_boundary && !w_stop_now && !w_empty);
  assign w_underrun_set = (r_state == RUN) && w_boundary && !w_stop_now && w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_stop_pending <= 1'b0;
      r_ena          <= 1'b0;
      r_running      <= 1'b0;
      r_data         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= PRIME;
        end
        PRIME: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_enter_run) begin
            r_state   <= RUN;
            r_ena     <= 1'b1;
            r_running <= 1'b1;
            r_data    <= w_rd_data;
          end
        end
        RUN: begin
          if (w_boundary) begin
            if (w_stop_now) begin
              r_state        <= IDLE;
              r_ena          <= 1'b0;
              r_running      <= 1'b0;
              r_data         <= '0;
              r_stop_pending <= 1'b0;
            end else begin
              // Empty FIFO plays a mute frame.
              r_data <= w_empty ? '0 : w_rd_data;
            end
          end else if (stop) begin
            r_stop_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Frame phase restarts at RUN entry so the first frame is a full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_phase <= '0;
    else if (w_enter_run) r_phase <= '0;
    else if (w_x64)       r_phase <= r_phase + PW'(1);
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_underrun_set) begin
        r_underrun     <= 1'b1;
        r_underrun_cnt <= sat_inc16(r_underrun_cnt);
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign ena          = r_ena;
  assign running      = r_running;
  assign data         = r_data;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
module tb_i2s_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        x512, x64, ena, running, underrun;
  logic        underrun_clr = 1'b0;
  logic [31:0] data;
  logic [15:0] underrun_cnt;
  logic [4:0]  fifo_level;

  i2s_tx_scheduler #(.CLK_DIV_X512(4), .FIFO_DEPTH(16), .START_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ena_sampleRatex512(x512), .ena_sampleRatex64(x64),
    .ena(ena), .data(data), .running(running),
    .underrun(underrun), .underrun_clr(underrun_clr),
    .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic e512;
    logic e64;
  } en_vec_t;

  typedef struct {
    logic [31:0] d;
    int          lvl;
    logic        rdy;
  } fill_vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  en_vec_t     en_tbl[12];
  fill_vec_t   fill_tbl[17];
  logic [31:0] words[4];
  int          entry;
  int          b1, b2, b3, b4, b5, b6;
  int          guard;

  initial begin
    // x512 every 4 clocks from cycle 3, x64 every 32 from cycle 31
    en_tbl[0]  = '{0,  1'b0, 1'b0};
    en_tbl[1]  = '{1,  1'b0, 1'b0};
    en_tbl[2]  = '{3,  1'b1, 1'b0};
    en_tbl[3]  = '{4,  1'b0, 1'b0};
    en_tbl[4]  = '{7,  1'b1, 1'b0};
    en_tbl[5]  = '{27, 1'b1, 1'b0};
    en_tbl[6]  = '{30, 1'b0, 1'b0};
    en_tbl[7]  = '{31, 1'b1, 1'b1};
    en_tbl[8]  = '{32, 1'b0, 1'b0};
    en_tbl[9]  = '{35, 1'b1, 1'b0};
    en_tbl[10] = '{63, 1'b1, 1'b1};
    en_tbl[11] = '{64, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      fill_tbl[i].d   = 32'hA000_0000 + 32'(i);
      fill_tbl[i].lvl = (i < 16) ? i + 1 : 16;
      fill_tbl[i].rdy = (i < 15) ? 1'b1 : 1'b0;
    end

    words[0] = 32'h1111_AAAA;
    words[1] = 32'h2222_BBBB;
    words[2] = 32'h3333_CCCC;
    words[3] = 32'h4444_DDDD;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", ena, 0);
    chk("rst_data", data, 0);
    chk("rst_running", running, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);
    rst = 1'b0;
    cyc = 0;

    // ---- enable generator table ----
    for (int i = 0; i < 12; i++) begin
      go_to(en_tbl[i].cyc);
      chk($sformatf("x512_c%0d", en_tbl[i].cyc), x512, en_tbl[i].e512);
      chk($sformatf("x64_c%0d", en_tbl[i].cyc), x64, en_tbl[i].e64);
      chk($sformatf("ena_idle_c%0d", en_tbl[i].cyc), ena, 0);
    end

    // ---- prime with 4 words, start, enter RUN ----
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      tick();
    end
    s_valid = 1'b0;
    chk("prime_level", fifo_level, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!ena && guard < 200) begin
      tick();
      guard++;
    end
    chk("enter_run_seen", ena, 1);
    entry = cyc;
    chk("enter_run_cycle", entry, 96);
    chk("run_data_w0", data, words[0]);
    chk("run_running", running, 1);
    chk("run_level_after_pop", fifo_level, 3);

    b1 = entry + 2048; b2 = b1 + 2048; b3 = b2 + 2048;
    b4 = b3 + 2048;    b5 = b4 + 2048; b6 = b5 + 2048;

    // ---- frame boundaries ----
    go_to(b1 - 1);
    chk("pre_b1_data", data, words[0]);
    tick();
    chk("b1_data_w1", data, words[1]);
    go_to(b2);
    chk("b2_data_w2", data, words[2]);
    go_to(b3);
    chk("b3_data_w3", data, words[3]);
    chk("b3_level", fifo_level, 0);
    go_to(b4 - 1);
    chk("pre_b4_underrun", underrun, 0);
    tick();
    chk("b4_data_mute", data, 0);
    chk("b4_underrun", underrun, 1);
    chk("b4_underrun_cnt", underrun_cnt, 1);
    chk("b4_ena", ena, 1);

    // plain clear
    go_to(b4 + 5);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_underrun", underrun, 0);
    chk("clr_keeps_cnt", underrun_cnt, 1);

    // clear coincident with a new underrun: set wins
    go_to(b5 - 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("b5_set_wins", underrun, 1);
    chk("b5_underrun_cnt", underrun_cnt, 2);

    // ---- stop at phase 10 ----
    go_to(b5 + 32 * 10 + 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    go_to(b6 - 1);
    chk("stop_ena_held", ena, 1);
    chk("stop_running_held", running, 1);
    tick();
    chk("stop_ena_off", ena, 0);
    chk("stop_data_zero", data, 0);
    chk("stop_running_off", running, 0);
    chk("stop_no_underrun", underrun_cnt, 2);

    // ---- fill FIFO to full while idle ----
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1;
      s_data  = fill_tbl[i].d;
      tick();
      chk($sformatf("fill_level_%0d", i), fifo_level, fill_tbl[i].lvl);
      chk($sformatf("fill_ready_%0d", i), s_ready, fill_tbl[i].rdy);
    end
    s_valid = 1'b0;
    chk("idle_ena_after_fill", ena, 0);

    // start with full FIFO: first word out is the oldest
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!ena && guard < 100) begin
      tick();
      guard++;
    end
    chk("rerun_seen", ena, 1);
    chk("rerun_data", data, fill_tbl[0].d);
    chk("rerun_level", fifo_level, 15);
    chk("rerun_s_ready", s_ready, 1);

    // ---- async reset mid-RUN ----
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ena", ena, 0);
    chk("arst_data", data, 0);
    chk("arst_running", running, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_underrun_cnt", underrun_cnt, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_s_ready", s_ready, 1);
    chk("arst_x512", x512, 0);
    chk("arst_x64", x64, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    tick();
    tick();
    chk("restart_x512_c2", x512, 0);
    tick();
    chk("restart_x512_c3", x512, 1);
    chk("restart_ena", ena, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
